// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types, defaults and helpers for the posted-write buffer
package mem_wb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      READ  = 2'd2
   } wb_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/mem_write_buffer_if.sv
// rtl/mem_write_buffer_if.sv - pipeline and backend signal bundle of the write buffer
interface mem_write_buffer_if import mem_wb_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              mem_r_en;
   logic              mem_w_en;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              freeze;
   logic              wb_empty;
   logic              be_rd_en;
   logic              be_wr_en;
   logic [ADDR_W-1:0] be_address;
   logic [DATA_W-1:0] be_wdata;
   logic [DATA_W-1:0] be_rdata;
   logic              be_ready;

   // master is the pipeline plus backend environment, slave is the buffer itself
   modport master (
      output mem_r_en, mem_w_en, address, wdata, be_rdata, be_ready,
      input  rdata, freeze, wb_empty, be_rd_en, be_wr_en, be_address, be_wdata
   );

   modport slave (
      input  mem_r_en, mem_w_en, address, wdata, be_rdata, be_ready,
      output rdata, freeze, wb_empty, be_rd_en, be_wr_en, be_address, be_wdata
   );

endinterface

// File: rtl/wb_fifo_cam.sv
// rtl/wb_fifo_cam.sv - circular store queue with youngest-match address search
module wb_fifo_cam import mem_wb_pkg::*; #(
   parameter int  ADDR_W = DEF_ADDR_W,
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  DEPTH  = DEF_DEPTH,
   localparam int PTR_W  = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [PTR_W:0]    count,
   output logic              full,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [PTR_W:0]    count_q;
   logic [PTR_W-1:0]  idx;

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + 1'b1;
         if (pop)  head_q <= head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Validity comes from count, so the storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= push_addr;
         data_q[tail_q] <= push_data;
      end
   end

   // Walk oldest to youngest so the last match seen wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (((PTR_W+1)'(i) < count_q) && (addr_q[idx] == lookup_addr)) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];
   assign count     = count_q;
   assign full      = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - posted-write buffer between MEM stage and memory backend
module mem_write_buffer import mem_wb_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input logic                clk,
   input logic                rst,
   mem_write_buffer_if.slave  bus
);
   localparam int PTR_W = clog2(DEPTH);

   wb_state_t         state_q;
   wb_state_t         state_d;
   logic              load;
   logic              store;
   logic              hit;
   logic              full;
   logic              pop;
   logic              push;
   logic              store_stall;
   logic              load_miss;
   logic              read_done;
   logic [PTR_W:0]    count;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] hit_data;

   // A simultaneous load and store is resolved as a store.
   assign load        = bus.mem_r_en && !bus.mem_w_en;
   assign store       = bus.mem_w_en;
   assign load_miss   = load && !hit;
   assign pop         = (state_q == DRAIN) && bus.be_ready;
   assign read_done   = (state_q == READ) && bus.be_ready;
   assign push        = store && (!full || pop);
   assign store_stall = store && full && !pop;

   wb_fifo_cam #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .push_addr   (bus.address),
      .push_data   (bus.wdata),
      .pop         (pop),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .count       (count),
      .full        (full),
      .lookup_addr (bus.address),
      .hit         (hit),
      .hit_data    (hit_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      bus.be_rd_en   = 1'b0;
      bus.be_wr_en   = 1'b0;
      bus.be_address = '0;
      bus.be_wdata   = '0;
      bus.rdata      = '0;
      bus.freeze     = store_stall || (load_miss && !read_done);
      bus.wb_empty   = (count == '0) && (state_q != DRAIN);

      case (state_q)
         IDLE: begin
            // A stalled store implies a full queue and no load, so it drains here.
            if (load_miss)                     state_d = READ;
            else if ((count != '0) || push)    state_d = DRAIN;
         end
         DRAIN: begin
            bus.be_wr_en   = 1'b1;
            bus.be_address = head_addr;
            bus.be_wdata   = head_data;
            if (bus.be_ready) state_d = IDLE;
         end
         READ: begin
            bus.be_rd_en   = 1'b1;
            bus.be_address = bus.address;
            if (bus.be_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         if (hit)            bus.rdata = hit_data;
         else if (read_done) bus.rdata = bus.be_rdata;
      end
   end

endmodule

// File: tb/tb_mem_write_buffer.sv
// tb/tb_mem_write_buffer.sv - directed vector bench for mem_write_buffer
module tb_mem_write_buffer;
   import mem_wb_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_write_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_write_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic          r;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          f;
      logic [DW-1:0] rd;
      logic          brd;
      logic          bwr;
      logic          emp;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;

   int  be_lat  = 1;
   bit  be_hold = 1'b1;
   int  be_cnt  = 0;
   logic [DW-1:0] mem_model [logic [AW-1:0]];
   logic [AW-1:0] log_addr [$];
   logic [DW-1:0] log_data [$];
   logic [AW-1:0] exp_addr [$];
   logic [DW-1:0] exp_data [$];

   // Backend model: decides be_ready on the falling edge, counting request cycles.
   initial begin
      bus.be_ready = 1'b0;
      bus.be_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            bus.be_ready = 1'b0;
            bus.be_rdata = '0;
            be_cnt       = 0;
         end else if (bus.be_ready) begin
            bus.be_ready = 1'b0;
            bus.be_rdata = '0;
            be_cnt       = 0;
         end else if ((bus.be_wr_en || bus.be_rd_en) && !be_hold) begin
            be_cnt++;
            if (be_cnt >= be_lat) begin
               bus.be_ready = 1'b1;
               if (bus.be_wr_en) begin
                  mem_model[bus.be_address] = bus.be_wdata;
                  log_addr.push_back(bus.be_address);
                  log_data.push_back(bus.be_wdata);
               end else begin
                  bus.be_rdata = mem_model.exists(bus.be_address) ? mem_model[bus.be_address] : '0;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.mem_r_en = r;
      bus.mem_w_en = w;
      bus.address  = a;
      bus.wdata    = d;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b0;
      drive(0, 0, '0, '0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      log_addr.delete();
      log_data.delete();
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic wait_empty(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         next_cycle();
         mid();
         if (bus.wb_empty) break;
      end
      chk({tag, "_drained"}, bus.wb_empty, 1'b1);
   endtask

   task automatic chk_log(input string tag);
      chk({tag, "_log_len"}, log_addr.size(), exp_addr.size());
      if (log_addr.size() == exp_addr.size()) begin
         for (int i = 0; i < exp_addr.size(); i++) begin
            chk($sformatf("%s_log%0d_addr", tag, i), log_addr[i], exp_addr[i]);
            chk($sformatf("%s_log%0d_data", tag, i), log_data[i], exp_data[i]);
         end
      end
   endtask

   vec_t vecs [9];

   initial begin
      int k;
      //            r  w  addr      data      frz rdata    brd bwr emp
      vecs[0] = '{1'b0, 1'b0, 32'h00, 32'h0000, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b1, 32'h20, 32'hAAAA, 1'b0, 32'h0000, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 32'h20, 32'hBBBB, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0000, 1'b0, 32'hBBBB, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 32'h30, 32'h1111, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h30, 32'h0000, 1'b0, 32'h1111, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 32'h20, 32'hCCCC, 1'b0, 32'h0000, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 32'h20, 32'h0000, 1'b0, 32'hCCCC, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 32'h40, 32'h2222, 1'b1, 32'h0000, 1'b0, 1'b1, 1'b0};

      drive(0, 0, '0, '0);
      next_cycle();
      next_cycle();
      mid();
      chk("rst_empty",   bus.wb_empty,   1'b1);
      chk("rst_freeze",  bus.freeze,     1'b0);
      chk("rst_be_wr",   bus.be_wr_en,   1'b0);
      chk("rst_be_rd",   bus.be_rd_en,   1'b0);
      chk("rst_rdata",   bus.rdata,      32'h0);
      chk("rst_be_addr", bus.be_address, 32'h0);
      rst = 1'b1;

      // Forwarding and fill with the backend stalled
      be_hold = 1'b1;
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         drive(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
         mid();
         chk($sformatf("vec%0d_freeze", i), bus.freeze,   vecs[i].f);
         chk($sformatf("vec%0d_rdata", i),  bus.rdata,    vecs[i].rd);
         chk($sformatf("vec%0d_be_rd", i),  bus.be_rd_en, vecs[i].brd);
         chk($sformatf("vec%0d_be_wr", i),  bus.be_wr_en, vecs[i].bwr);
         chk($sformatf("vec%0d_empty", i),  bus.wb_empty, vecs[i].emp);
      end

      // Full buffer: 5th store waits for the first drain completion
      next_cycle();
      mid();
      chk("full_still_frozen", bus.freeze, 1'b1);
      next_cycle();
      be_lat  = 1;
      be_hold = 1'b0;
      mid();
      chk("full_ready_seen", bus.be_ready, 1'b1);
      chk("full_push_pop_freeze", bus.freeze, 1'b0);
      next_cycle();
      be_lat = 3;
      drive(1, 0, 32'h40, '0);
      mid();
      chk("full_fifth_hit", bus.rdata, 32'h2222);
      chk("full_fifth_freeze", bus.freeze, 1'b0);
      next_cycle();
      drive(0, 0, '0, '0);
      wait_empty("full", 80);
      exp_addr = '{32'h20, 32'h20, 32'h30, 32'h20, 32'h40};
      exp_data = '{32'hAAAA, 32'hBBBB, 32'h1111, 32'hCCCC, 32'h2222};
      chk_log("full");

      // Posted stores at full rate with a 3-cycle backend
      do_reset();
      be_hold = 1'b0;
      be_lat  = 3;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         drive(0, 1, 32'h10 + 32'(4 * i), 32'hD0 + 32'(i));
         mid();
         chk($sformatf("posted%0d_freeze", i), bus.freeze, 1'b0);
      end
      next_cycle();
      drive(0, 0, '0, '0);
      wait_empty("posted", 60);
      exp_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};
      exp_data = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
      chk_log("posted");

      // Load miss from IDLE goes ahead of the queued stores
      do_reset();
      be_hold = 1'b1;
      mem_model[32'h40] = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         drive(0, 1, 32'h50 + 32'(4 * i), 32'h500 + 32'(i));
      end
      next_cycle();
      drive(0, 0, '0, '0);
      next_cycle();
      be_lat  = 1;
      be_hold = 1'b0;
      mid();
      chk("bypass_first_drain", bus.be_wr_en, 1'b1);
      next_cycle();
      drive(1, 0, 32'h40, '0);
      mid();
      chk("bypass_idle_freeze", bus.freeze, 1'b1);
      chk("bypass_idle_be_wr", bus.be_wr_en, 1'b0);
      chk("bypass_idle_be_rd", bus.be_rd_en, 1'b0);
      next_cycle();
      mid();
      chk("bypass_read_be_rd", bus.be_rd_en, 1'b1);
      chk("bypass_read_be_wr", bus.be_wr_en, 1'b0);
      chk("bypass_read_addr", bus.be_address, 32'h40);
      chk("bypass_rdata", bus.rdata, 32'h1234);
      chk("bypass_freeze_low", bus.freeze, 1'b0);
      next_cycle();
      drive(0, 0, '0, '0);
      wait_empty("bypass", 40);
      exp_addr = '{32'h50, 32'h54, 32'h58};
      exp_data = '{32'h500, 32'h501, 32'h502};
      chk_log("bypass");

      // Load miss while a drain is waiting: drain finishes first
      do_reset();
      be_hold = 1'b1;
      mem_model[32'h70] = 32'h5678;
      next_cycle();
      drive(0, 1, 32'h60, 32'h6);
      next_cycle();
      drive(1, 0, 32'h70, '0);
      mid();
      chk("mdrain_freeze0", bus.freeze, 1'b1);
      chk("mdrain_be_wr0", bus.be_wr_en, 1'b1);
      chk("mdrain_be_rd0", bus.be_rd_en, 1'b0);
      next_cycle();
      mid();
      chk("mdrain_freeze1", bus.freeze, 1'b1);
      chk("mdrain_be_rd1", bus.be_rd_en, 1'b0);
      next_cycle();
      be_lat  = 1;
      be_hold = 1'b0;
      mid();
      chk("mdrain_done_freeze", bus.freeze, 1'b1);
      chk("mdrain_done_be_rd", bus.be_rd_en, 1'b0);
      chk("mdrain_done_be_wr", bus.be_wr_en, 1'b1);
      k = 0;
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         mid();
         k = i;
         if (bus.be_rd_en) break;
         chk($sformatf("mdrain_wait%0d_freeze", i), bus.freeze, 1'b1);
      end
      chk("mdrain_rd_rise", bus.be_rd_en, 1'b1);
      chk("mdrain_rd_latency", (k <= 2), 1'b1);
      chk("mdrain_rd_addr", bus.be_address, 32'h70);
      chk("mdrain_rdata", bus.rdata, 32'h5678);
      chk("mdrain_freeze_low", bus.freeze, 1'b0);
      next_cycle();
      drive(0, 0, '0, '0);
      wait_empty("mdrain", 20);
      exp_addr = '{32'h60};
      exp_data = '{32'h6};
      chk_log("mdrain");

      // Reset mid-drain discards queued stores
      do_reset();
      be_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         drive(0, 1, 32'h80 + 32'(4 * i), 32'h800 + 32'(i));
      end
      next_cycle();
      drive(0, 0, '0, '0);
      mid();
      chk("rstq_be_wr", bus.be_wr_en, 1'b1);
      chk("rstq_empty", bus.wb_empty, 1'b0);
      next_cycle();
      rst = 1'b0;
      next_cycle();
      mid();
      chk("rstq_after_empty", bus.wb_empty, 1'b1);
      chk("rstq_after_be_wr", bus.be_wr_en, 1'b0);
      chk("rstq_after_freeze", bus.freeze, 1'b0);
      rst = 1'b1;
      mem_model[32'h84] = 32'h9999;
      next_cycle();
      drive(1, 0, 32'h84, '0);
      mid();
      chk("rstq_load_miss_freeze", bus.freeze, 1'b1);
      chk("rstq_load_miss_rdata", bus.rdata, 32'h0);
      next_cycle();
      be_lat  = 1;
      be_hold = 1'b0;
      mid();
      chk("rstq_read_be_rd", bus.be_rd_en, 1'b1);
      chk("rstq_read_rdata", bus.rdata, 32'h9999);
      next_cycle();
      drive(0, 0, '0, '0);
      next_cycle();
      next_cycle();
      mid();
      chk("rstq_no_writes", log_addr.size(), 0);
      chk("rstq_final_empty", bus.wb_empty, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Parametrised posted-write buffer between the MEM pipeline stage and the memory backend (cache or SRAM controller). Stores are accepted in one cycle into a DEPTH-entry FIFO and drained to the backend in the background. Loads that hit a buffered address are forwarded without a backend access; loads that miss bypass the queued writes. The block raises `freeze` to stall the pipeline only on a full buffer or a load miss.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data word width; no byte enables, whole-word accesses only
- `DEPTH`, 4, buffer entries; power of two, ≥2
- `clk` in 1, sole clock, rising edge
- `rst` in 1, synchronous, active-low reset
- `mem_r_en` in 1, load request from MEM stage; held stable while `freeze`=1
- `mem_w_en` in 1, store request; held stable while `freeze`=1
- `address` in ADDR_W, load/store address
- `wdata` in DATA_W, store data
- `rdata` out DATA_W, load data, valid in the cycle `mem_r_en`=1 and `freeze`=0
- `freeze` out 1, stall pipeline
- `wb_empty` out 1, buffer holds no entries and no drain is in flight
- `be_rd_en`, `be_wr_en` out 1, backend request, held until `be_ready`
- `be_address` out ADDR_W, `be_wdata` out DATA_W, backend address and data
- `be_rdata` in DATA_W, `be_ready` in 1, backend read data and one-cycle completion pulse

## Operation
- FSM states: IDLE, DRAIN, READ.
- IDLE:
  - load miss pending → READ;
  - else count>0 → DRAIN.
  - Load miss has priority over drain, unless a store is stalled on a full buffer; then DRAIN.
- DRAIN: `be_wr_en`=1, `be_address`/`be_wdata` = head entry. On `be_ready`: pop head, go to IDLE.
- READ: `be_rd_en`=1, `be_address`=`address`. On `be_ready`: `rdata`=`be_rdata` combinationally, go to IDLE.
- Store:
  - Pushed at the clock edge when `mem_w_en`=1 and (count<DEPTH or a pop occurs in the same cycle).
  - Otherwise `freeze`=1.
  - Same-address stores are not merged; each occupies its own entry.
- Load hit: `address` equals a valid entry's address (full-width compare). `rdata` = youngest matching entry, `freeze`=0, no backend access, in any state.
- Load miss:
  - `freeze`=1 until the `be_ready` cycle of its READ.
  - If DRAIN is in progress, the drain completes first; no abort.
- `mem_r_en` and `mem_w_en` both high is illegal; the block treats it as a store.
- Outputs in a given cycle:
  - `rdata` = 0 when there is no valid load.
  - Backend outputs = 0 when idle.
- Reset (`rst`=0 at an edge):
  - count=0, head/tail=0, state=IDLE.
  - All outputs 0, except `wb_empty`=1.
  - Buffered stores are discarded.
  - A backend transaction in flight is abandoned; the backend is reset on the same `rst`.

## Timing
- Store, not full: request at cycle t, `freeze`=0 at t, entry valid from t+1.
- Drain: a store pushed at t into an empty buffer in IDLE gives `be_wr_en`=1 from t+1; pop at the `be_ready` edge.
- Load hit: zero-latency forward, combinational from entry registers.
- Load miss at t in IDLE: `be_rd_en` high t+1..t+k (`be_ready` at t+k). `freeze` high t..t+k-1, low at t+k.
- Full buffer and `be_ready` for DRAIN in the same cycle: pop and push on the same edge, no freeze.
- Pointer wrap: head/tail are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits. Full is count==DEPTH.
- `be_*` request outputs are decoded from registered state; no combinational path from `mem_*` to `be_rd_en`/`be_wr_en`.

## Structure
- Package `mem_wb_pkg`: state enum (IDLE, DRAIN, READ), default parameter constants, clog2 helper.
- Sub-module `wb_fifo_cam`: storage, head/tail/count, push/pop, and youngest-match search. Outputs `hit` and `hit_data`.
- Top: FSM, freeze logic, backend muxing.

## Test plan
- Reset: drive `rst`=0 mid-drain with 3 entries queued → next cycle `wb_empty`=1, `be_wr_en`=0; a subsequent load to a queued address misses.
- Posted stores: 4 stores to 0x10..0x1C with `be_ready` 3 cycles after each request → no freeze; backend sees 4 writes in order, data intact.
- Full buffer: DEPTH=4, stores held off by `be_ready`=0, 5th store → `freeze`=1 until the first `be_ready`. The 5th is pushed on that edge; count stays 4.
- Forwarding: stores 0x20←0xAAAA then 0x20←0xBBBB, then load 0x20 → `rdata`=0xBBBB, `freeze`=0, no `be_rd_en`.
- Load miss bypass: 2 stores queued, load 0x40 (memory holds 0x1234) while IDLE → READ before DRAIN; `rdata`=0x1234 at the `be_ready` cycle.
- Load miss during drain: load issued while DRAIN waits → `be_rd_en` rises only the cycle after the drain `be_ready`; `freeze` holds throughout.
